// File: rtl/axi_chan_fifo_pkg.sv
// rtl/axi_chan_fifo_pkg.sv - shared types and default sizing for the channel FIFO
package axi_chan_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 16;
  localparam int unsigned DEF_ADDR_SIZE    = 4;
  localparam int unsigned DEF_AFULL_THRESH = 12;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/dual_ram.sv
// rtl/dual_ram.sv - plain storage array: clocked write port, asynchronous read port
module dual_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_SIZE  = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rstn,
  input  logic                  wr_en,
  input  logic [ADDR_SIZE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  full,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Writes are also blocked while held in reset so a stray wr_en cannot corrupt storage.
  always_ff @(posedge wr_clk) begin
    if (wr_rstn && wr_en && !full) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_chan_fifo.sv
// rtl/axi_chan_fifo.sv - valid/ready channel buffer: RAM-backed queue with a registered output beat
module axi_chan_fifo
  import axi_chan_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_SIZE    = DEF_ADDR_SIZE,
  parameter int unsigned AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_SIZE:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  logic [ADDR_SIZE:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  s_ready_q, s_ready_d;
  out_state_e            state_q, state_d;

  logic                  wr_en;
  logic                  rd_en;
  logic                  full_next;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]) &&
                 (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]);

  assign wr_en = s_valid && s_ready_q;
  // The output register takes a new word whenever it is free or being drained this cycle.
  assign rd_en = !empty && ((state_q == OUT_IDLE) || m_ready);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{ADDR_SIZE{1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{ADDR_SIZE{1'b0}}, rd_en};
    m_data_d  = m_data_q;
    state_d   = state_q;
    if (rd_en) begin
      m_data_d = rd_data;
      state_d  = OUT_VALID;
    end else if ((state_q == OUT_VALID) && m_ready) begin
      state_d  = OUT_IDLE;
    end
    full_next = (wr_ptr_d[ADDR_SIZE] != rd_ptr_d[ADDR_SIZE]) &&
                (wr_ptr_d[ADDR_SIZE-1:0] == rd_ptr_d[ADDR_SIZE-1:0]);
    s_ready_d = !full_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      state_q   <= OUT_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
      state_q   <= state_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = (state_q == OUT_VALID);
  assign m_data      = m_data_q;
  assign count       = (wr_ptr_q - rd_ptr_q) + {{ADDR_SIZE{1'b0}}, m_valid};
  assign almost_full = (32'(count) >= AFULL_THRESH);

  dual_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_ram (
    .wr_clk  (clk),
    .wr_rstn (rstn),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_SIZE-1:0]),
    .wr_data (s_data),
    .full    (full),
    .rd_addr (rd_ptr_q[ADDR_SIZE-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axi_chan_fifo.sv
// tb/tb_axi_chan_fifo.sv - scoreboard bench for axi_chan_fifo
module tb_axi_chan_fifo;

  logic        clk;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  axi_chan_fifo #(
    .DATA_WIDTH   (16),
    .ADDR_SIZE    (4),
    .AFULL_THRESH (12)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge: logs the handshakes the next rising edge will complete.
  task automatic tick();
    if (s_valid && s_ready) exp_q.push_back(s_data);
    if (m_valid && m_ready) got_q.push_back(m_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b1; s_data = 16'hDEAD; m_ready = 1'b1;
    repeat (3) tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got e=%b f=%b af=%b want 1 0 0", empty, full, almost_full);
    end
    n_cmp++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data got %h want 0000", m_data); end
    rstn = 1'b1; s_valid = 1'b0;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready got %b want 1", s_ready); end
    n_cmp++; if (count !== 5'd0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL reset_no_accept got count=%0d q=%0d want 0 0", count, exp_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_single();
    logic [15:0] e;
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (m_valid !== 1'b0 || count !== 5'd1) begin
      n_fail++; $display("FAIL single_no_bypass got mv=%b count=%0d want 0 1", m_valid, count);
    end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_latency got mv=%b data=%h want 1 1234", m_valid, m_data);
    end
    tick();
    n_cmp++; if (m_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL single_drained got mv=%b count=%0d want 0 0", m_valid, count);
    end
    n_cmp++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL single_scoreboard got out=%0d in=%0d want 1 1", got_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got_q[0] !== e) begin n_fail++; $display("FAIL single_data got %h want %h", got_q[0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      tick();
      n_cmp++; if (count !== 5'(i) || almost_full !== (i >= 12)) begin
        n_fail++; $display("FAIL fill_count_%0d got count=%0d af=%b want %0d %b", i, count, almost_full, i, (i >= 12));
      end
    end
    s_valid = 1'b1; s_data = 16'h0012;
    repeat (3) tick();
    n_cmp++; if (s_ready !== 1'b0 || full !== 1'b1 || count !== 5'd17) begin
      n_fail++; $display("FAIL fill_full got rdy=%b full=%b count=%0d want 0 1 17", s_ready, full, count);
    end
    n_cmp++; if (exp_q.size() != 17) begin
      n_fail++; $display("FAIL fill_accepted got %0d want 17", exp_q.size());
    end
    s_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [15:0] e;
    m_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid_%0d got %b want 1", i, m_valid); end
      tick();
      if (i == 1) begin
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL drain_s_ready got %b want 1", s_ready); end
      end
    end
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_end got e=%b count=%0d mv=%b want 1 0 0", empty, count, m_valid);
    end
    for (int i = 1; i <= 17; i++) begin
      n_cmp++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL drain_order_%0d got missing want %h", i, 16'(i)); break;
      end
      e = exp_q.pop_front();
      if (got_q[0] !== e || e !== 16'(i)) begin
        n_fail++; $display("FAIL drain_order_%0d got %h want %h", i, got_q[0], 16'(i));
      end
      void'(got_q.pop_front());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stream();
    int idx = 0;
    int cyc = 0;
    logic hold;
    logic [15:0] held;
    logic [15:0] e;
    logic [15:0] g;
    while (got_q.size() < 100 && cyc < 3000) begin
      s_valid = (idx < 100) && ($urandom_range(0, 4) != 0);
      s_data  = 16'hA000 + 16'(idx);
      m_ready = ($urandom_range(0, 2) != 0);
      if (s_valid && s_ready) idx++;
      hold = m_valid && !m_ready;
      held = m_data;
      tick();
      cyc++;
      if (hold) begin
        n_cmp++; if (m_valid !== 1'b1 || m_data !== held) begin
          n_fail++; $display("FAIL stream_stall got mv=%b data=%h want 1 %h", m_valid, m_data, held);
        end
      end
    end
    s_valid = 1'b0; m_ready = 1'b0;
    n_cmp++; if (got_q.size() != 100) begin
      n_fail++; $display("FAIL stream_timeout got %0d beats want 100", got_q.size());
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL stream_extra got %h want none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL stream_data got %h want %h", g, e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'h5500 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL midrst_pre_count got %0d want 5", count); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || count !== 5'd0 || s_ready !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async got mv=%b count=%0d rdy=%b e=%b want 0 0 0 1", m_valid, count, s_ready, empty);
    end
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete(); got_q.delete();
    tick();
    s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    while (got_q.size() == 0 && cyc < 10) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL midrst_first got none want beef");
    end else if (got_q[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL midrst_first got %h want beef", got_q[0]);
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_chan_fifo.md
# axi_chan_fifo

Single-clock, valid/ready-handshaked buffer that sits in front of each crossbar channel: it accepts beats from an AXI channel source, stores them in the dual-port RAM, and presents them through a registered output stage to the downstream arbiter/slave port. It owns all pointer, full/empty and occupancy logic, so the RAM stays a pure storage array.

## Interface
- DATA_WIDTH, 16, beat width in bits (payload of one AXI channel beat)
- ADDR_SIZE, 4, RAM address width; RAM depth DEPTH = 2^ADDR_SIZE
- AFULL_THRESH, 12, almost_full asserts when count >= this value (1..DEPTH+1)
- clk  in  1  single clock; rising edge
- rstn  in  1  reset; asynchronous, active-low
- s_valid  in  1  upstream beat valid
- s_ready  out  1  buffer can accept; registered
- s_data  in  DATA_WIDTH  upstream beat
- m_valid  out  1  output beat valid; registered
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  output beat; registered
- count  out  ADDR_SIZE+1  total beats held (RAM + output register), 0..DEPTH+1
- full  out  1  RAM full (DEPTH beats in RAM)
- empty  out  1  RAM empty
- almost_full  out  1  count >= AFULL_THRESH

## Operation
- Pointers wr_ptr, rd_ptr: ADDR_SIZE+1 bits; low ADDR_SIZE bits address the RAM, MSB is wrap bit. empty = (wr_ptr == rd_ptr); full = MSBs differ, low bits equal.
- Write: s_valid && s_ready -> RAM[wr_ptr] <= s_data, wr_ptr += 1 (wraps modulo 2^(ADDR_SIZE+1)). RAM full input tied to full. s_data ignored when s_ready = 0.
- s_ready register = !full_next, where full_next is computed from next-cycle pointers; no combinational path from m_ready or s_valid to s_ready.
- Output stage, two states:
  - IDLE (m_valid=0): if RAM not empty -> load m_data <= RAM[rd_ptr], rd_ptr += 1, go VALID.
  - VALID (m_valid=1): if m_ready && RAM not empty -> reload next word, stay VALID; if m_ready && RAM empty -> go IDLE; if !m_ready -> hold m_data unchanged.
- Simultaneous RAM write and RAM read in one cycle is legal; occupancy unchanged.
- No write bypass: a beat never reaches m_data in the cycle it is accepted.
- count = (wr_ptr - rd_ptr) + m_valid, width ADDR_SIZE+1; max DEPTH+1.
- full/empty/count/almost_full are combinational from registers only.

## Timing
- Reset (async assert, sync release on edge): wr_ptr=rd_ptr=0, m_valid=0, m_data=0, s_ready=0, count=0, empty=1, full=0, almost_full=0 (for AFULL_THRESH>=1).
- s_ready rises on first clk edge after rstn deasserts.
- Latency: beat accepted at edge N into empty buffer -> m_valid=1 with that beat after edge N+1 (2 edges).
- Throughput: 1 beat/cycle sustained in and out.
- Full: when RAM holds DEPTH beats, s_ready=0 next cycle; upstream must hold. A pop at edge N that frees RAM space -> s_ready=1 after edge N.
- Backpressure: m_valid && !m_ready -> m_valid, m_data stable until handshake.
- Reset mid-operation: all contents discarded immediately; outputs to reset values without a clock.

## Structure
- Shared package: none required; DEPTH = 1 << ADDR_SIZE as localparam.
- Sub-module: storage is the existing dual_ram, instantiated with wr_clk = rd_clk = clk, wr_rstn = rstn, wr_en = s_valid && s_ready, full = full, rd_addr = rd_ptr low bits.
- Pointer/flag logic, output stage and count in this module.

## Test plan
- Reset: hold rstn=0 with s_valid=1 -> s_ready=0, m_valid=0, count=0, empty=1; s_ready=1 one edge after release; no beat accepted during reset.
- Single beat: push 0x1234 at edge N, m_ready=1 -> m_valid=1, m_data=0x1234 after edge N+1; popped next edge, count returns 0.
- Fill: m_ready=0, push 0x0001..0x0011 -> 17 beats accepted, count=17, full=1, s_ready=0, almost_full=1 from count 12; 18th beat held, not written.
- Drain order: from full, m_ready=1 -> m_data 0x0001..0x0011 in order, one per cycle, s_ready=1 after first pop, empty/count reach 1/0.
- Streaming + wrap: continuous push and pop of 100 incrementing beats with random m_ready stalls -> output sequence identical, pointers wrap, m_data stable during every stall.
- Mid-operation reset: 5 beats buffered, assert rstn=0 between edges -> m_valid, count drop to 0 immediately; after release, new beat 0xBEEF is first out.
